// File: rtl/gb_pkg.sv
// Shared constants and types for the cartridge-side bus stage.
// CPU address windows, the MBC1 RAM enable magic and FSM state encoding.
package gb_pkg;

    localparam logic [15:0] ROM0_HI  = 16'h3FFF;
    localparam logic [15:0] ROMX_HI  = 16'h7FFF;
    localparam logic [15:0] ERAM_LO  = 16'hA000;
    localparam logic [15:0] ERAM_HI  = 16'hBFFF;
    localparam logic [15:0] BOOT_END = 16'h00FF;

    localparam logic [3:0] RAM_EN_MAGIC = 4'hA;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mbc_state_t;

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 bank/mode/enable registers and CPU-to-physical address translation.
// External RAM banking is only built when MBC1_RAM_EN is defined.
module mbc1_regs
    import gb_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int MEM_ADDR_W    = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [14:0]           addr_i,
    input  logic [4:0]            data_i,
    output logic                  ram_en_o,
`ifdef MBC1_RAM_EN
    output logic [MEM_ADDR_W-1:0] ram_addr_o,
`endif
    output logic [MEM_ADDR_W-1:0] rom_addr_o
);

    localparam logic [6:0] ROM_MASK = 7'((1 << ROM_BANK_BITS) - 1);

    logic [4:0] bank_lo_q, bank_lo_d;
    logic [1:0] bank_hi_q, bank_hi_d;
    logic       mode_q, mode_d;
    logic [6:0] rom_bank;

    always_comb begin
        bank_lo_d = bank_lo_q;
        bank_hi_d = bank_hi_q;
        mode_d    = mode_q;
        if (wr_i) begin
            unique case (addr_i[14:13])
                2'd0: ;
                // bank 0 is not selectable in the switchable window
                2'd1: bank_lo_d = (data_i == 5'd0) ? 5'd1 : data_i;
                2'd2: bank_hi_d = data_i[1:0];
                2'd3: mode_d    = data_i[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_lo_q <= 5'd1;
            bank_hi_q <= 2'd0;
            mode_q    <= 1'b0;
        end else begin
            bank_lo_q <= bank_lo_d;
            bank_hi_q <= bank_hi_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        if (addr_i > ROM0_HI[14:0])
            rom_bank = {bank_hi_q, bank_lo_q};
        else
            rom_bank = mode_q ? {bank_hi_q, 5'b0} : 7'd0;
    end

    assign rom_addr_o = MEM_ADDR_W'({rom_bank & ROM_MASK, addr_i[13:0]});

`ifdef MBC1_RAM_EN
    localparam int         LOW_W    = MEM_ADDR_W - 1;
    localparam logic [1:0] RAM_MASK = 2'((1 << RAM_BANK_BITS) - 1);

    logic       ram_en_q;
    logic [1:0] rbank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ram_en_q <= 1'b0;
        else if (wr_i && addr_i[14:13] == 2'd0)
            ram_en_q <= (data_i[3:0] == RAM_EN_MAGIC);
    end

    assign ram_en_o   = ram_en_q;
    assign rbank      = (mode_q ? bank_hi_q : 2'd0) & RAM_MASK;
    assign ram_addr_o = {1'b1, LOW_W'({rbank, addr_i[12:0]})};
`else
    assign ram_en_o = 1'b0;
`endif

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge stage: claims ROM/RAM windows and fetches over req/ack.
// Define MBC1_RAM_EN to build the external RAM window.
module cart_mbc1
    import gb_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int MEM_ADDR_W    = 22
) (
    input  logic                  clockgb,
    input  logic                  resetn,
    input  logic [15:0]           address,
    input  logic [7:0]            indata,
    output logic [7:0]            outdata,
    input  logic                  load,
    input  logic                  store,
    input  logic                  boot_active,
    output logic                  ready,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    mbc_state_t            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            out_q, out_d;

    logic                  rom_claim, eram_win, ram_en, ram_hit, reg_wr;
    logic [MEM_ADDR_W-1:0] rom_addr, tgt_addr;

    assign rom_claim = (address <= ROMX_HI) &&
                       !(boot_active && address <= BOOT_END);
    assign eram_win  = (address >= ERAM_LO) && (address <= ERAM_HI);
    assign ram_hit   = eram_win && ram_en;

`ifdef MBC1_RAM_EN
    logic [MEM_ADDR_W-1:0] ram_addr;
    assign tgt_addr = eram_win ? ram_addr : rom_addr;
`else
    assign tgt_addr = rom_addr;
`endif

    mbc1_regs #(
        .ROM_BANK_BITS (ROM_BANK_BITS),
        .RAM_BANK_BITS (RAM_BANK_BITS),
        .MEM_ADDR_W    (MEM_ADDR_W)
    ) u_regs (
        .clk        (clockgb),
        .rst_n      (resetn),
        .wr_i       (reg_wr),
        .addr_i     (address[14:0]),
        .data_i     (indata[4:0]),
        .ram_en_o   (ram_en),
`ifdef MBC1_RAM_EN
        .ram_addr_o (ram_addr),
`endif
        .rom_addr_o (rom_addr)
    );

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        out_d   = out_q;
        reg_wr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // store has priority over a simultaneous load
                if (store) begin
                    if (rom_claim) begin
                        reg_wr = 1'b1;
                    end else if (ram_hit) begin
                        state_d = ST_REQ;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = tgt_addr;
                        wdata_d = indata;
                    end
                end else if (load) begin
                    if (rom_claim || ram_hit) begin
                        state_d = ST_REQ;
                        ready_d = 1'b0;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = tgt_addr;
                    end else if (eram_win) begin
                        out_d = 8'hFF;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    if (!we_q)
                        out_d = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            out_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
        end
    end

    assign outdata   = out_q;
    assign ready     = ready_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cart_mbc1.sv
// Bench for cart_mbc1: random bus traffic against a behavioural model.
// Builds with or without MBC1_RAM_EN; the model follows the same define.
module tb_cart_mbc1;

`ifdef MBC1_RAM_EN
    localparam bit RAM_ON = 1'b1;
`else
    localparam bit RAM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address = 16'h0;
    logic [7:0]  indata = 8'h0;
    logic [7:0]  outdata;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        boot_active = 1'b0;
    logic        ready;
    logic [21:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;

    cart_mbc1 dut (
        .clockgb     (clk),
        .resetn      (rst_n),
        .address     (address),
        .indata      (indata),
        .outdata     (outdata),
        .load        (load),
        .store       (store),
        .boot_active (boot_active),
        .ready       (ready),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // behavioural model: cartridge registers and outstanding transfer
    int         m_ram_en = 0, m_lo = 1, m_hi = 0, m_mode = 0;
    bit         m_busy = 0, m_we = 0;
    int         m_addr = 0, m_wdata = 0;
    logic [7:0] m_out = 8'hFF;

    function automatic int rom_phys(input int a);
        int bank;
        if (a < 'h4000) bank = m_mode ? m_hi * 32 : 0;
        else            bank = m_hi * 32 + m_lo;
        return (bank % 128) * 16384 + a % 16384;
    endfunction

    function automatic int ram_phys(input int a);
        return 2097152 + ((m_mode ? m_hi : 0) % 4) * 8192 + a % 8192;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ram_en = 0; m_lo = 1; m_hi = 0; m_mode = 0;
            m_busy = 0; m_we = 0; m_addr = 0; m_wdata = 0;
            m_out = 8'hFF;
        end else if (m_busy) begin
            if ((load || store) && !mem_ack) begin
                miscompares++;
                $display("FAIL strobe_while_busy at %0t", $time);
            end
            if (mem_ack) begin
                m_busy = 0;
                if (!m_we) m_out = mem_rdata;
            end
        end else begin
            int a;
            bit rom_c, in_eram, ram_ok;
            a       = int'(address);
            rom_c   = (a <= 'h7FFF) && !(boot_active && a <= 'hFF);
            in_eram = (a >= 'hA000) && (a <= 'hBFFF);
            ram_ok  = RAM_ON && (m_ram_en != 0);
            if (store) begin
                if (rom_c) begin
                    case (a / 8192)
                        0: m_ram_en = (int'(indata) % 16 == 10);
                        1: m_lo = (int'(indata) % 32 == 0) ? 1 : int'(indata) % 32;
                        2: m_hi = int'(indata) % 4;
                        default: m_mode = int'(indata) % 2;
                    endcase
                end else if (in_eram && ram_ok) begin
                    m_busy = 1; m_we = 1;
                    m_addr = ram_phys(a); m_wdata = int'(indata);
                end
            end else if (load) begin
                if (rom_c) begin
                    m_busy = 1; m_we = 0; m_addr = rom_phys(a);
                end else if (in_eram && ram_ok) begin
                    m_busy = 1; m_we = 0; m_addr = ram_phys(a);
                end else if (in_eram) begin
                    m_out = 8'hFF;
                end
            end
        end
    end

    // memory controller: acks after a random or forced number of cycles
    int         force_delay = -1;
    int         ack_cnt = 0;
    bit         counting = 0;
    logic [7:0] last_rdata = 8'h0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            counting = 0;
            mem_ack  = 0;
        end else if (m_busy) begin
            if (!counting) begin
                ack_cnt  = (force_delay >= 0) ? force_delay : $urandom_range(0, 4);
                counting = 1;
            end
            if (ack_cnt == 0) begin
                mem_ack    = 1;
                mem_rdata  = 8'($urandom);
                last_rdata = mem_rdata;
                counting   = 0;
            end else begin
                mem_ack = 0;
                ack_cnt--;
            end
        end else begin
            counting  = 0;
            mem_ack   = ($urandom_range(0, 7) == 0);
            mem_rdata = 8'($urandom);
        end
    end

    // compare process plus request capture for the directed checks
    int          req_count = 0;
    int          low_cnt = 0;
    bit          prev_req = 0;
    logic [21:0] last_req_addr = '0;
    logic        last_we = 0;
    logic [7:0]  last_wdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", ready, 1);
            chk("rst_req", mem_req, 0);
            chk("rst_out", outdata, 8'hFF);
            chk("rst_addr", mem_addr, 0);
            prev_req = 0;
        end else begin
            chk("ready", ready, !m_busy);
            chk("mem_req", mem_req, m_busy);
            chk("outdata", outdata, m_out);
            if (m_busy) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (!ready) low_cnt++;
            if (mem_req && !prev_req) begin
                req_count++;
                last_req_addr = mem_addr;
                last_we       = mem_we;
                last_wdata    = mem_wdata;
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (m_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy after %0d cycles", n);
        end
    endtask

    task automatic access(input bit st, input bit ld,
                          input logic [15:0] a, input logic [7:0] d);
        wait_idle();
        address = a; indata = d; store = st; load = ld;
        @(posedge clk); #2;
        store = 0; load = 0;
        wait_idle();
    endtask

    int          rc;
    logic [21:0] prev_addr;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_rst_outdata", outdata, 8'hFF);
        chk("lit_rst_ready", ready, 1);
        chk("lit_rst_we", mem_we, 0);
        chk("lit_rst_wdata", mem_wdata, 0);
        @(posedge clk); #2;

        boot_active = 1;
        rc = req_count;
        access(0, 1, 16'h0050, 8'h00);
        chk("lit_boot_noreq", req_count, rc);
        chk("lit_boot_out", outdata, 8'hFF);
        boot_active = 0;
        access(0, 1, 16'h0050, 8'h00);
        chk("lit_boot_off_addr", last_req_addr, 22'h000050);
        chk("lit_boot_off_out", outdata, last_rdata);

        access(1, 0, 16'h2000, 8'h00);
        access(0, 1, 16'h4123, 8'h00);
        chk("lit_bank0_as_1", last_req_addr, 22'h004123);
        access(1, 0, 16'h2000, 8'h05);
        access(1, 0, 16'h4000, 8'h01);
        chk("lit_model_rom", rom_phys('h7FFF), 'h097FFF);
        access(0, 1, 16'h7FFF, 8'h00);
        chk("lit_bank25", last_req_addr, 22'h097FFF);

        access(1, 0, 16'h6000, 8'h01);
        access(1, 0, 16'h4000, 8'h02);
        access(0, 1, 16'h0010, 8'h00);
        chk("lit_mode1_rom0", last_req_addr, 22'h100010);
        access(1, 0, 16'h6000, 8'h00);
        access(0, 1, 16'h0010, 8'h00);
        chk("lit_mode0_rom0", last_req_addr, 22'h000010);

        access(1, 0, 16'h0000, 8'h00);
        rc = req_count;
        access(0, 1, 16'hA000, 8'h00);
        chk("lit_ram_off_noreq", req_count, rc);
        chk("lit_ram_off_out", outdata, 8'hFF);
        access(1, 0, 16'h0000, 8'h0A);
        access(1, 0, 16'h6000, 8'h01);
        access(1, 0, 16'h4000, 8'h03);
        rc = req_count;
        prev_addr = last_req_addr;
        access(1, 0, 16'hA001, 8'h5C);
        chk("lit_ram_wr_req", req_count, rc + (RAM_ON ? 1 : 0));
        chk("lit_ram_wr_addr", last_req_addr, RAM_ON ? 22'h206001 : prev_addr);
        if (req_count != rc) begin
            chk("lit_ram_wr_we", last_we, 1);
            chk("lit_ram_wr_data", last_wdata, 8'h5C);
        end

        force_delay = 4;
        low_cnt = 0;
        access(0, 1, 16'h4000, 8'h00);
        chk("lit_lat5_low", low_cnt, 5);
        chk("lit_lat5_out", outdata, last_rdata);
        force_delay = 0;
        low_cnt = 0;
        access(0, 1, 16'h5000, 8'h00);
        chk("lit_lat_min_low", low_cnt, 1);

        force_delay = 10;
        address = 16'h4000; load = 1;
        @(posedge clk); #2;
        load = 0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_req_drop", mem_req, 0);
        chk("lit_rst_ready_up", ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        force_delay = -1;
        access(0, 1, 16'h4000, 8'h00);
        chk("lit_rst_bank1", last_req_addr, 22'h004000);

        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          op;
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(0, 'hFF));
                1: a = 16'($urandom_range(0, 'h1FFF));
                2: a = 16'($urandom_range('h2000, 'h7FFF));
                3: a = 16'($urandom_range('hA000, 'hBFFF));
                default: a = ($urandom_range(0, 1) == 0) ?
                             16'($urandom_range('h8000, 'h9FFF)) :
                             16'($urandom_range('hC000, 'hFFFF));
            endcase
            d = ($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom);
            boot_active = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 4);
            access(op >= 3, op != 3, a, d);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #2;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
